// File: rtl/addr_latch_bank.sv
// Addressable latch bank: a synchronised write strobe updates one bit, or all bits, of a register.
// Optional feature macro ADDR_LATCH_SHADOW_EN: writes go to a staging register, and COMMIT copies it to Q.
module addr_latch_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter int               SYNC_STAGES = 2,
    localparam int              AW          = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [AW-1:0]    ADDR,
    input  logic             DIN,
    input  logic [1:0]       MODE,
    input  logic             nBITW,
    input  logic             COMMIT,
    output logic [WIDTH-1:0] Q,
    output logic             CHANGED,
    output logic             PENDING
);

    typedef enum logic [1:0] {
        MODE_LATCH = 2'b00,
        MODE_DEMUX = 2'b01,
        MODE_CLEAR = 2'b10,
        MODE_SET   = 2'b11
    } mode_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   sync_prev_q, sync_prev_d;
    logic                   armed_q, armed_d;
    logic                   wr_event;
    logic [WIDTH-1:0]       q_q, q_d;
    logic                   changed_q, changed_d;
    mode_e                  wr_mode;

    assign wr_mode = mode_e'(MODE);

    function automatic logic [WIDTH-1:0] write_value(
        input logic [WIDTH-1:0] base,
        input mode_e            m,
        input logic [AW-1:0]    a,
        input logic             d
    );
        logic [WIDTH-1:0] v;
        v = base;
        case (m)
            MODE_LATCH: v[a] = d;
            MODE_DEMUX: begin
                v    = '0;
                v[a] = d;
            end
            MODE_CLEAR: v = '0;
            MODE_SET:   v = '1;
        endcase
        return v;
    endfunction

    // vld tracks which synchroniser stages hold real samples since reset. The bank
    // arms only after a real high has reached the output, so a strobe still held
    // low across reset release cannot produce a write.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], nBITW};
        vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
        sync_prev_d = sync_q[SYNC_STAGES-1];
        armed_d     = armed_q | (vld_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1]);
        wr_event    = armed_q & sync_prev_q & ~sync_q[SYNC_STAGES-1];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q      <= '1;
            vld_q       <= '0;
            sync_prev_q <= 1'b1;
            armed_q     <= 1'b0;
            q_q         <= INIT;
            changed_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            vld_q       <= vld_d;
            sync_prev_q <= sync_prev_d;
            armed_q     <= armed_d;
            q_q         <= q_d;
            changed_q   <= changed_d;
        end
    end

`ifdef ADDR_LATCH_SHADOW_EN
    logic [WIDTH-1:0] s_q, s_d;
    logic             pending_q, pending_d;

    // A commit in the event cycle forwards the freshly written staging value.
    always_comb begin
        s_d = s_q;
        if (wr_event) begin
            s_d = write_value(s_q, wr_mode, ADDR, DIN);
        end
        q_d       = COMMIT ? s_d : q_q;
        pending_d = (s_d != q_d);
        changed_d = (q_d != q_q);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s_q       <= INIT;
            pending_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            pending_q <= pending_d;
        end
    end

    assign PENDING = pending_q;
`else
    logic unused_commit;

    always_comb begin
        q_d = q_q;
        if (wr_event) begin
            q_d = write_value(q_q, wr_mode, ADDR, DIN);
        end
        changed_d = (q_d != q_q);
    end

    assign unused_commit = COMMIT;
    assign PENDING       = 1'b0;
`endif

    assign Q       = q_q;
    assign CHANGED = changed_q;

endmodule

// File: doc/addr_latch_bank.md
ADDR_LATCH_BANK -- requirements
Module: addr_latch_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of latch bits; legal values are powers of two from 2 to 64.
REQ-002 Parameter INIT, default all-zero WIDTH bits, SHALL set the value of Q after reset.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the depth of the strobe synchroniser; legal values are 2 to 4.
REQ-004 Localparam AW SHALL equal log2(WIDTH).
REQ-005 CLK  in  1  SHALL be the system clock; the block SHALL have one clock.
REQ-006 RESET  in  1  SHALL be the reset, asynchronous and active-high.
REQ-007 ADDR  in  AW  SHALL be the bit index of the write.
REQ-008 DIN  in  1  SHALL be the data bit of the write.
REQ-009 MODE  in  2  SHALL select the write mode: 00 latch, 01 demux, 10 clear-all, 11 set-all.
REQ-010 nBITW  in  1  SHALL be the active-low write strobe, asynchronous to CLK.
REQ-011 COMMIT  in  1  SHALL be the shadow commit pulse; it is ignored without the shadow option.
REQ-012 Q  out  WIDTH  SHALL be the registered latch outputs.
REQ-013 CHANGED  out  1  SHALL pulse for one cycle when Q changes value.
REQ-014 PENDING  out  1  SHALL be high when staged data differs from Q.

Function
REQ-015 nBITW SHALL pass through SYNC_STAGES flip-flops clocked by CLK; a high-to-low transition at the synchroniser output SHALL be one write event.
REQ-016 At a write event, ADDR, DIN and MODE SHALL be sampled in that cycle; they are required stable from the nBITW fall until SYNC_STAGES+2 CLK edges later.
REQ-017 Holding nBITW low SHALL produce exactly one write event; the next event requires nBITW to return high for at least SYNC_STAGES cycles.
REQ-018 Latch mode SHALL set target bit [ADDR] to DIN and leave all other bits unchanged.
REQ-019 Demux mode SHALL set target bit [ADDR] to DIN and clear all other bits.
REQ-020 Clear-all mode SHALL set every target bit to 0, and set-all mode SHALL set every target bit to 1; ADDR and DIN are ignored in both.
REQ-021 The target SHALL be Q directly, with the new value visible on the CLK edge that ends the event cycle; total latency from the nBITW fall is SYNC_STAGES+1 edges.
REQ-022 CHANGED SHALL be high for the single cycle after any Q bit changes, and low when a write leaves Q unchanged.
REQ-023 Without the shadow option, PENDING SHALL be constant 0.

Reset
REQ-024 While RESET is high: Q=INIT, staging register=INIT, synchroniser flops=1, CHANGED=0, PENDING=0.
REQ-025 Asserting RESET in the middle of a write SHALL discard the write; the first event after release requires a fresh nBITW fall.
REQ-026 A transition of Q caused by reset SHALL NOT pulse CHANGED.

Configuration
REQ-027 Macro ADDR_LATCH_SHADOW_EN defined SHALL make the write target a WIDTH-bit staging register S instead of Q.
REQ-028 With ADDR_LATCH_SHADOW_EN, a cycle with COMMIT high SHALL load Q from S on the next edge.
REQ-029 With ADDR_LATCH_SHADOW_EN, PENDING SHALL equal (S != Q), registered.
REQ-030 With ADDR_LATCH_SHADOW_EN, a write event coinciding with COMMIT SHALL update S, and Q SHALL receive the updated S in the same edge.
REQ-031 Without ADDR_LATCH_SHADOW_EN, S and COMMIT logic SHALL be absent and writes SHALL behave per REQ-021.

Verification
REQ-032 WIDTH=8, latch mode: ADDR=7, DIN=1, nBITW pulsed low -> Q=0x80 after 3 edges with CHANGED high for 1 cycle; repeating the same write -> no CHANGED.
REQ-033 Q=0xFF, demux mode: ADDR=2, DIN=1 -> Q=0x04; then clear-all -> Q=0x00; then set-all -> Q=0xFF.
REQ-034 nBITW held low for 20 cycles in latch mode toggling DIN -> exactly one write, Q reflects DIN at event cycle only.
REQ-035 RESET asserted 1 cycle after nBITW falls, released 2 cycles later while nBITW stays low -> Q=INIT, no write, CHANGED stays 0.
REQ-036 ADDR_LATCH_SHADOW_EN, WIDTH=16: writes to bits 3 and 9 -> Q unchanged and PENDING=1; COMMIT pulse -> Q=0x0208, PENDING=0, one CHANGED pulse.
REQ-037 ADDR_LATCH_SHADOW_EN: write event and COMMIT in the same cycle -> Q includes the new bit on that edge.
